// File: rtl/key_pkg.sv
// Shared types and defaults for the keypad entry block: debouncer state
// encoding, the no-key code and the default build parameters.
package key_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_PRESS_DB   = 2'd1,
        ST_HELD       = 2'd2,
        ST_RELEASE_DB = 2'd3
    } key_state_e;

    localparam logic [3:0] NO_KEY = 4'd0;
    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int DEPTH_DEF = 4;

    // Encoder codes 10..15 are not keys and behave like an idle keypad.
    function automatic logic [3:0] sanitize_code(input logic [3:0] code);
        return (code > 4'd9) ? NO_KEY : code;
    endfunction

endpackage

// File: rtl/key_entry_if.sv
// Keypad entry bus: encoder input and clear in, debounced key and digit buffer out.
// key_valid is a single-cycle pulse with no backpressure; the sink must take it when it is high.
interface key_entry_if #(
    parameter int DEPTH = 4
) ();
    logic [3:0]         key_code;
    logic               clear;
    logic               key_valid;
    logic [3:0]         key_value;
    logic [4*DEPTH-1:0] digits;
    logic [3:0]         count;
    logic               full;
    logic               overflow;
    logic [1:0]         state;

    modport master (
        output key_code, clear,
        input  key_valid, key_value, digits, count, full, overflow, state
    );

    modport slave (
        input  key_code, clear,
        output key_valid, key_value, digits, count, full, overflow, state
    );
endinterface

// File: rtl/key_debounce.sv
// Keypad debouncer: a press or release is accepted only after DEBOUNCE_CYCLES
// consecutive identical samples; each accepted press gives one key_valid pulse.
module key_debounce
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_code,
    output logic       accept,
    output logic [3:0] accept_code,
    output logic       key_valid,
    output logic [3:0] key_value,
    output key_state_e state
);
    localparam logic [3:0] LAST_CNT = 4'(DEBOUNCE_CYCLES - 1);

    logic [3:0] sample;
    logic [3:0] candidate;
    logic [3:0] counter;

    // accept fires on the edge where the press counter would reach DEBOUNCE_CYCLES,
    // so the buffer can update on the same edge that registers key_valid.
    always_comb begin
        sample      = sanitize_code(key_code);
        accept      = (state == ST_PRESS_DB) && (sample == candidate) &&
                      (sample != NO_KEY) && (counter == LAST_CNT);
        accept_code = candidate;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            candidate <= NO_KEY;
            counter   <= 4'd0;
            key_valid <= 1'b0;
            key_value <= NO_KEY;
        end else begin
            key_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (sample != NO_KEY) begin
                        candidate <= sample;
                        counter   <= 4'd1;
                        state     <= ST_PRESS_DB;
                    end
                end
                ST_PRESS_DB: begin
                    if (sample == NO_KEY) begin
                        state <= ST_IDLE;
                    end else if (sample == candidate) begin
                        counter <= counter + 4'd1;
                        if (accept) begin
                            state     <= ST_HELD;
                            key_valid <= 1'b1;
                            key_value <= candidate;
                        end
                    end else begin
                        candidate <= sample;
                        counter   <= 4'd1;
                    end
                end
                ST_HELD: begin
                    if (sample == NO_KEY) begin
                        counter <= 4'd1;
                        state   <= ST_RELEASE_DB;
                    end
                end
                ST_RELEASE_DB: begin
                    if (sample == NO_KEY) begin
                        counter <= counter + 4'd1;
                        if (counter == LAST_CNT) begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        state <= ST_HELD;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/key_entry.sv
// Keypad digit entry: debounced presses shift BCD digits into a DEPTH-nibble
// buffer, newest in the low nibble; presses into a full buffer set sticky overflow.
module key_entry
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int DEPTH           = DEPTH_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    key_entry_if.slave  bus
);
    localparam logic [3:0] COUNT_MAX = 4'(DEPTH);

    logic               accept;
    logic [3:0]         accept_code;
    key_state_e         fsm_state;
    logic [4*DEPTH-1:0] digits;
    logic [3:0]         count;
    logic               overflow;

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_code    (bus.key_code),
        .accept      (accept),
        .accept_code (accept_code),
        .key_valid   (bus.key_valid),
        .key_value   (bus.key_value),
        .state       (fsm_state)
    );

    // Clear takes priority over a coinciding press; the debouncer still reports it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            digits   <= '0;
            count    <= 4'd0;
            overflow <= 1'b0;
        end else if (bus.clear) begin
            digits   <= '0;
            count    <= 4'd0;
            overflow <= 1'b0;
        end else if (accept) begin
            if (count < COUNT_MAX) begin
                digits <= (digits << 4) | (4*DEPTH)'(accept_code);
                count  <= count + 4'd1;
            end else begin
                overflow <= 1'b1;
            end
        end
    end

    assign bus.digits   = digits;
    assign bus.count    = count;
    assign bus.overflow = overflow;
    assign bus.full     = (count == COUNT_MAX);
    assign bus.state    = fsm_state;
endmodule

// File: tb/tb_key_entry.sv
// Bench for key_entry: directed scenarios plus random keypad traffic, checked
// against a sample-history reference model through a key_value scoreboard.
module tb_key_entry;
    localparam int DB    = 4;
    localparam int DEPTH = 4;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    key_entry_if #(.DEPTH(DEPTH)) bus ();

    key_entry #(
        .DEBOUNCE_CYCLES (DB),
        .DEPTH           (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: press accepted when armed and the last DB samples are one
    // equal nonzero code; re-armed after DB consecutive no-key samples
    int         hist[$];
    bit         armed = 1'b1;
    int         buf_q[$];
    bit         m_ovf = 1'b0;
    bit         m_valid = 1'b0;
    int         m_value = 0;
    logic [3:0] exp_q[$];

    function automatic bit last_all(input int v);
        if (hist.size() < DB) return 1'b0;
        for (int i = 0; i < DB; i++) if (hist[hist.size() - 1 - i] != v) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [4*DEPTH-1:0] model_digits();
        logic [4*DEPTH-1:0] v;
        v = '0;
        foreach (buf_q[i]) v = (v << 4) | (4*DEPTH)'(buf_q[i]);
        return v;
    endfunction

    always @(posedge clk) begin
        int s;
        if (!rst_n) begin
            hist.delete();
            buf_q.delete();
            armed   = 1'b1;
            m_ovf   = 1'b0;
            m_valid = 1'b0;
            m_value = 0;
        end else begin
            s = (bus.key_code > 9) ? 0 : int'(bus.key_code);
            hist.push_back(s);
            if (hist.size() > DB) void'(hist.pop_front());
            m_valid = 1'b0;
            if (armed && s != 0 && last_all(s)) begin
                armed   = 1'b0;
                m_valid = 1'b1;
                m_value = s;
                exp_q.push_back(4'(s));
                if (!bus.clear) begin
                    if (buf_q.size() < DEPTH) buf_q.push_back(s);
                    else m_ovf = 1'b1;
                end
            end else if (!armed && last_all(0)) begin
                armed = 1'b1;
            end
            if (bus.clear) begin
                buf_q.delete();
                m_ovf = 1'b0;
            end
        end
    end

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        logic [3:0] e;
        check("key_valid", bus.key_valid, m_valid);
        if (bus.key_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("pulse_value", bus.key_value, e);
            end
        end
        check("key_value_held", bus.key_value, m_value);
        check("digits", bus.digits, model_digits());
        check("count", bus.count, buf_q.size());
        check("full", bus.full, buf_q.size() == DEPTH);
        check("overflow", bus.overflow, m_ovf);
    end

    // driver tasks
    task automatic step(input logic [3:0] code, input logic clr);
        bus.key_code = code;
        bus.clear    = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] code, input int hold, input int rel);
        repeat (hold) step(code, 1'b0);
        repeat (rel) step(4'd0, 1'b0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.key_code = 4'd0;
        bus.clear    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_digits", bus.digits, 0);
        check("reset_state", bus.state, 0);
        rst_n = 1'b1;

        // single press: pulse on the 4th held sample
        repeat (3) step(4'd5, 1'b0);
        check("press5_no_early", bus.key_valid, 0);
        step(4'd5, 1'b0);
        check("press5_latency", bus.key_valid, 1);
        press(4'd5, 6, 10);
        check("press5_digits", bus.digits, 16'h0005);
        check("press5_count", bus.count, 1);

        // short bounce never accepted
        step(4'd3, 1'b0); step(4'd0, 1'b0); step(4'd3, 1'b0);
        step(4'd3, 1'b0); step(4'd0, 1'b0); step(4'd0, 1'b0);
        check("bounce_idle", bus.state, 0);
        check("bounce_count", bus.count, 1);

        // bounce during release gives one pulse only
        press(4'd3, 6, 2);
        press(4'd3, 1, 8);
        check("release_bounce_count", bus.count, 2);
        step(4'd0, 1'b1);

        // fill and overflow
        press(4'd1, 6, 6); press(4'd2, 6, 6); press(4'd3, 6, 6);
        press(4'd4, 6, 6); press(4'd7, 6, 6);
        check("fill_digits", bus.digits, 16'h1234);
        check("fill_full", bus.full, 1);
        check("fill_overflow", bus.overflow, 1);

        // clear on the accept edge of key 9 with two digits buffered
        step(4'd0, 1'b1);
        press(4'd8, 6, 6); press(4'd1, 6, 6);
        repeat (3) step(4'd9, 1'b0);
        step(4'd9, 1'b1);
        check("clear_accept_valid", bus.key_valid, 1);
        check("clear_accept_digits", bus.digits, 0);
        check("clear_accept_count", bus.count, 0);
        check("clear_accept_value", bus.key_value, 9);
        press(4'd9, 4, 6);

        // reset mid-debounce, key still held
        repeat (2) step(4'd6, 1'b0);
        rst_n = 1'b0;
        step(4'd6, 1'b0);
        check("rst_value", bus.key_value, 0);
        check("rst_valid", bus.key_valid, 0);
        check("rst_state", bus.state, 0);
        rst_n = 1'b1;
        repeat (3) step(4'd6, 1'b0);
        check("rst_no_early", bus.key_valid, 0);
        step(4'd6, 1'b0);
        check("rst_repress", bus.key_valid, 1);
        press(4'd6, 3, 8);

        // random traffic including invalid codes, clears and rare resets
        for (int n = 0; n < 150; n++) begin
            logic [3:0] c;
            int len;
            c   = 4'($urandom_range(0, 15));
            len = $urandom_range(1, 8);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
                step(c, $urandom_range(0, 39) == 0);
                rst_n = 1'b1;
            end
        end
        press(4'd0, 0, 8);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/key_entry.md
KEY_ENTRY -- requirements
Module: key_entry

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, 4: consecutive identical samples needed to accept a press or a release; legal range 2..15.
REQ-002 Parameter DEPTH, 4: number of BCD digits held in the entry buffer; legal range 1..8.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 key_code  input  4  keypad encoder output: 1..9 = key, 0 = no key.
REQ-006 clear  input  1  synchronous clear of the entry buffer.
REQ-007 key_valid  output  1  one-cycle pulse per accepted key press.
REQ-008 key_value  output  4  code of the last accepted key; held between pulses.
REQ-009 digits  output  4*DEPTH  entry buffer; newest digit in [3:0], older digits in higher nibbles.
REQ-010 count  output  4  number of valid digits in the buffer, 0..DEPTH.
REQ-011 full  output  1  high when count == DEPTH.
REQ-012 overflow  output  1  sticky: a press was accepted while full.

Function
REQ-013 key_code values 10..15 shall be treated exactly as 0 (no key).
REQ-014 The debouncer shall be an FSM with states IDLE, PRESS_DB, HELD, RELEASE_DB, plus a candidate register and a 4-bit stability counter.
REQ-015 IDLE: on a nonzero sample, latch it as candidate, set counter = 1, go to PRESS_DB; otherwise stay.
REQ-016 PRESS_DB, sample == candidate: increment the counter; the edge on which the counter reaches DEBOUNCE_CYCLES goes to HELD and accepts the press.
REQ-017 PRESS_DB, sample == 0: return to IDLE with no event.
REQ-018 PRESS_DB, different nonzero sample: latch it as the new candidate, set counter = 1, stay in PRESS_DB.
REQ-019 Accept means: key_valid = 1 and key_value = candidate, both registered on that same edge; key_valid is 0 on the next edge.
REQ-020 Latency: a code presented on edge N and held is accepted on edge N+DEBOUNCE_CYCLES-1, and key_valid is visible for the following cycle.
REQ-021 HELD: any nonzero sample (including a different code) stays in HELD with no event; a 0 sample sets counter = 1 and goes to RELEASE_DB.
REQ-022 RELEASE_DB: a 0 sample increments the counter; on reaching DEBOUNCE_CYCLES go to IDLE.
REQ-023 RELEASE_DB: a nonzero sample returns to HELD with no event (bounce on release).
REQ-024 On accept with count < DEPTH: digits shifts left one nibble, the new code is placed in [3:0], and count increments.
REQ-025 On accept with count == DEPTH: digits and count are unchanged, overflow is set, and key_valid still pulses.
REQ-026 clear: digits = 0, count = 0, overflow = 0 on that edge; the debouncer FSM is unaffected.
REQ-027 clear coinciding with accept: clear wins (buffer empty afterwards), while key_valid and key_value still update.
REQ-028 full shall be combinational from count.

Reset
REQ-029 With rst_n low at a rising edge: FSM = IDLE, counter = 0, candidate = 0, key_valid = 0, key_value = 0, digits = 0, count = 0, overflow = 0.
REQ-030 Reset asserted mid-debounce or mid-hold shall abort with no event; after release of reset, a key still held is treated as a new press from IDLE.

Structure
REQ-031 Package key_pkg shall hold the FSM state enum, the no-key code constant (0), and the default DEBOUNCE_CYCLES and DEPTH values.
REQ-032 Sub-module key_debounce shall contain the FSM, candidate register and counter, and output key_valid/key_value.
REQ-033 key_entry shall instantiate key_debounce and implement the buffer, count and overflow logic.

Verification (DEBOUNCE_CYCLES = 4, DEPTH = 4)
REQ-034 Hold key_code = 5 for 10 cycles, then 0 for 10 cycles -> exactly one key_valid pulse 4 cycles after the first 5 sample; key_value = 5; digits = 0x0005; count = 1.
REQ-035 Pattern 3,0,3,3,0 then 0 -> no key_valid; FSM back in IDLE; count = 0.
REQ-036 Press 3 and release, then press 3 during RELEASE_DB (0,0,3) and release -> one pulse only.
REQ-037 Press 1,2,3,4,7, each held and cleanly released -> digits = 0x1234, count = 4, full = 1, overflow = 1 after the 7; five key_valid pulses.
REQ-038 Assert clear on the exact key_valid edge for key 9 with count = 2 -> digits = 0, count = 0, key_value = 9.
REQ-039 Deassert rst_n for 1 cycle while 6 is in PRESS_DB (counter = 2), 6 still held -> all outputs 0 during reset; first pulse 4 cycles after reset release.
